demux_12_stream: RTL and testbench
==================================

# demux_12_stream

Registered 1-to-2 stream demultiplexer with packet-level routing: beats on one input stream are steered to one of two output streams chosen by a select line. The route is latched at the first beat of each packet and held until its last beat. It is the counterpart of the 2:1 data-path multiplexers and sits wherever a shared bus must be split between two consumers. Each output has a one-entry register, so the block gives one-cycle latency at full throughput.

## Interface
Parameters:
- WIDTH, 8, data width of every stream
- COUNT_W, 8, width of the per-output packet counters

Ports:
- clk  input  1  clock; all state updates on rising edge
- rst  input  1  asynchronous, active-high reset
- i  input  WIDTH  input beat data
- i_valid  input  1  input beat valid
- i_last  input  1  marks final beat of a packet
- i_ready  output  1  block accepts beat this cycle
- s  input  1  route select (0 → out0, 1 → out1), sampled only on a packet's first beat
- o0, o1  output  WIDTH  output beat data
- o0_valid, o1_valid  output  1  output beat valid
- o0_last, o1_last  output  1  final beat of packet on that output
- o0_ready, o1_ready  input  1  downstream accepts
- pkt0_cnt, pkt1_cnt  output  COUNT_W  packets completed into each output buffer

## Operation
- Handshake: a beat transfers when valid and ready are both high at a rising edge. Upstream holds i, i_last and s stable while i_valid=1 and i_ready=0. The block holds oN, oN_last and oN_valid stable while oN_valid=1 and oN_ready=0.
- States: IDLE (no packet open), PKT0 and PKT1 (packet open, locked to that output).
- Target output: s in IDLE; 0 in PKT0; 1 in PKT1.
- i_ready = target slot empty, or target slot being drained this cycle (oT_valid & oT_ready). It is combinational from state, s and oT_ready.
- Accept in IDLE with i_last=0 → PKT{s}. Accept in IDLE with i_last=1 (single-beat packet) → remain IDLE.
- Accept in PKTn with i_last=1 → IDLE. Any other accept, or no accept → state unchanged.
- s is ignored in PKT0 and PKT1. i_valid may drop between beats with no state change.
- On accept, the target slot loads {i, i_last} and sets valid. The non-target slot is unaffected and keeps draining independently.
- Slot drained with no new load → valid clears. Simultaneous drain and load → valid stays 1 with the new data.
- pktN_cnt increments by 1 when a beat with i_last=1 is accepted into slot N. It wraps from 2^COUNT_W−1 to 0.

## Timing
- Reset values: state IDLE; o0, o1 = 0; o0_valid, o1_valid, o0_last, o1_last = 0; pkt0_cnt, pkt1_cnt = 0. i_ready = 1 during and after reset, since both slots are empty.
- Reset asserted mid-packet: buffered beats are discarded and the open packet is abandoned. The next accepted beat is treated as a first beat.
- Latency: a beat accepted at edge N is visible on oT/oT_valid after edge N and remains valid until the edge at which oT_ready=1.
- Throughput: 1 beat/cycle per packet when the target oT_ready is held high.
- Counters update at the same edge the last beat is accepted.

## Structure
- Package demux_12_pkg: state typedef (IDLE, PKT0, PKT1) and the output index constants OUT0=0, OUT1=1.
- Sub-module demux_slot: one-entry register (data, last, valid) with load/drain handshake, parameterised by WIDTH. Instantiated twice.
- Top level contains the FSM, target selection, i_ready logic and the counters.

## Test plan
- Reset, then a 3-beat packet with s=1, data 0x11/0x22/0x33, o1_ready=1: o1 shows 0x11, 0x22, 0x33 on consecutive cycles; o1_last=1 only with 0x33; o0_valid stays 0; pkt1_cnt=1.
- Toggle s to 0 after the first beat of a 4-beat packet started with s=1: all 4 beats go to out1, state returns to IDLE, and the next packet with s=0 goes to out0.
- Backpressure: hold o0_ready=0 during a packet to out0: first beat buffered, i_ready=0 from the next cycle, o0 holds 0xA5. Release o0_ready: one beat/cycle resumes with no loss or duplication.
- Single-beat packets alternating s=0,1,0,1 with both readys high: one beat per cycle, routed alternately; pkt0_cnt=2, pkt1_cnt=2; state never leaves IDLE.
- COUNT_W=2, five single-beat packets to out0: pkt0_cnt sequence 1, 2, 3, 0, 1.
- Assert rst mid-packet while o1 holds an unconsumed beat: o1_valid=0 immediately; the next beat with s=0 routes to out0.

Source files
------------

// File: rtl/demux_12_pkg.sv
// Shared types for the 1-to-2 packet stream demultiplexer.
// Holds the routing FSM states and the output index constants.
package demux_12_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      PKT0 = 2'd1,
      PKT1 = 2'd2
   } state_t;

   localparam logic OUT0 = 1'b0;
   localparam logic OUT1 = 1'b1;

endpackage

// File: rtl/demux_slot.sv
// One-entry output register (data, last, valid) with load/drain handshake.
// o_avail tells the producer a load this cycle will not overwrite a pending beat.
module demux_slot #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             i_load,
   input  logic [WIDTH-1:0] i_data,
   input  logic             i_last,
   input  logic             i_ready,
   output logic [WIDTH-1:0] o_data,
   output logic             o_last,
   output logic             o_valid,
   output logic             o_avail
);

   logic [WIDTH-1:0] r_data;
   logic             r_last;
   logic             r_valid;
   logic             w_drain;

   assign w_drain = r_valid & i_ready;
   assign o_avail = ~r_valid | i_ready;

   // Load wins over drain so a simultaneous drain+load keeps valid high with new data.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_data  <= '0;
         r_last  <= 1'b0;
         r_valid <= 1'b0;
      end else if (i_load) begin
         r_data  <= i_data;
         r_last  <= i_last;
         r_valid <= 1'b1;
      end else if (w_drain) begin
         r_valid <= 1'b0;
      end
   end

   assign o_data  = r_data;
   assign o_last  = r_last;
   assign o_valid = r_valid;

endmodule

// File: rtl/demux_12_stream.sv
// Registered 1-to-2 stream demultiplexer with packet-level routing.
// The route is latched on a packet's first beat and held until its last beat.
module demux_12_stream
   import demux_12_pkg::*;
#(
   parameter int WIDTH   = 8,
   parameter int COUNT_W = 8
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [WIDTH-1:0]   i,
   input  logic               i_valid,
   input  logic               i_last,
   output logic               i_ready,
   input  logic               s,
   output logic [WIDTH-1:0]   o0,
   output logic [WIDTH-1:0]   o1,
   output logic               o0_valid,
   output logic               o1_valid,
   output logic               o0_last,
   output logic               o1_last,
   input  logic               o0_ready,
   input  logic               o1_ready,
   output logic [COUNT_W-1:0] pkt0_cnt,
   output logic [COUNT_W-1:0] pkt1_cnt
);

   state_t             r_state;
   state_t             w_next;
   logic               w_tgt;
   logic               w_avail0;
   logic               w_avail1;
   logic               w_accept;
   logic               w_load0;
   logic               w_load1;
   logic [COUNT_W-1:0] r_cnt0;
   logic [COUNT_W-1:0] r_cnt1;

   // s only matters while no packet is open.
   always_comb begin
      w_tgt = s;
      case (r_state)
         PKT0:    w_tgt = OUT0;
         PKT1:    w_tgt = OUT1;
         default: w_tgt = s;
      endcase
   end

   assign i_ready  = (w_tgt == OUT1) ? w_avail1 : w_avail0;
   assign w_accept = i_valid & i_ready;
   assign w_load0  = w_accept & (w_tgt == OUT0);
   assign w_load1  = w_accept & (w_tgt == OUT1);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   always_comb begin
      w_next = r_state;
      if (w_accept) begin
         case (r_state)
            IDLE: begin
               if (!i_last) begin
                  w_next = (s == OUT1) ? PKT1 : PKT0;
               end
            end
            PKT0, PKT1: begin
               if (i_last) begin
                  w_next = IDLE;
               end
            end
            default: w_next = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_cnt0 <= '0;
         r_cnt1 <= '0;
      end else begin
         if (w_load0 && i_last) begin
            r_cnt0 <= r_cnt0 + 1'b1;
         end
         if (w_load1 && i_last) begin
            r_cnt1 <= r_cnt1 + 1'b1;
         end
      end
   end

   assign pkt0_cnt = r_cnt0;
   assign pkt1_cnt = r_cnt1;

   demux_slot #(.WIDTH(WIDTH)) u_slot0 (
      .clk     (clk),
      .rst     (rst),
      .i_load  (w_load0),
      .i_data  (i),
      .i_last  (i_last),
      .i_ready (o0_ready),
      .o_data  (o0),
      .o_last  (o0_last),
      .o_valid (o0_valid),
      .o_avail (w_avail0)
   );

   demux_slot #(.WIDTH(WIDTH)) u_slot1 (
      .clk     (clk),
      .rst     (rst),
      .i_load  (w_load1),
      .i_data  (i),
      .i_last  (i_last),
      .i_ready (o1_ready),
      .o_data  (o1),
      .o_last  (o1_last),
      .o_valid (o1_valid),
      .o_avail (w_avail1)
   );

endmodule

// File: tb/tb_demux_12_stream.sv
// Directed bench for demux_12_stream with hand-computed expected values.
module tb_demux_12_stream;

   localparam int WIDTH   = 8;
   localparam int COUNT_W = 2;

   logic               clk = 1'b0;
   logic               rst;
   logic [WIDTH-1:0]   i;
   logic               i_valid;
   logic               i_last;
   logic               i_ready;
   logic               s;
   logic [WIDTH-1:0]   o0;
   logic [WIDTH-1:0]   o1;
   logic               o0_valid;
   logic               o1_valid;
   logic               o0_last;
   logic               o1_last;
   logic               o0_ready;
   logic               o1_ready;
   logic [COUNT_W-1:0] pkt0_cnt;
   logic [COUNT_W-1:0] pkt1_cnt;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   demux_12_stream #(.WIDTH(WIDTH), .COUNT_W(COUNT_W)) dut (
      .clk      (clk),
      .rst      (rst),
      .i        (i),
      .i_valid  (i_valid),
      .i_last   (i_last),
      .i_ready  (i_ready),
      .s        (s),
      .o0       (o0),
      .o1       (o1),
      .o0_valid (o0_valid),
      .o1_valid (o1_valid),
      .o0_last  (o0_last),
      .o1_last  (o1_last),
      .o0_ready (o0_ready),
      .o1_ready (o1_ready),
      .pkt0_cnt (pkt0_cnt),
      .pkt1_cnt (pkt1_cnt)
   );

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s got %0h expected %0h", tag, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      step();
      step();
      rst = 1'b0;
   endtask

   task automatic drive(input logic v, input logic [WIDTH-1:0] d, input logic l, input logic sel);
      i_valid = v;
      i       = d;
      i_last  = l;
      s       = sel;
   endtask

   initial begin
      rst = 1'b0; i = '0; i_valid = 1'b0; i_last = 1'b0; s = 1'b0;
      o0_ready = 1'b1; o1_ready = 1'b1;
      #1 rst = 1'b1;
      #1;
      chk("rst_iready_during", i_ready, 1);
      step();
      step();
      rst = 1'b0;
      #1;
      chk("rst_o0_valid", o0_valid, 0);
      chk("rst_o1_valid", o1_valid, 0);
      chk("rst_o0", o0, 0);
      chk("rst_o1", o1, 0);
      chk("rst_lasts", {o0_last, o1_last}, 0);
      chk("rst_cnts", {pkt0_cnt, pkt1_cnt}, 0);
      chk("rst_iready_after", i_ready, 1);

      // 3-beat packet to out1
      drive(1, 8'h11, 0, 1);
      step();
      chk("p3_b1_o1", o1, 8'h11);
      chk("p3_b1_v", o1_valid, 1);
      chk("p3_b1_last", o1_last, 0);
      chk("p3_b1_o0v", o0_valid, 0);
      drive(1, 8'h22, 0, 1);
      step();
      chk("p3_b2_o1", o1, 8'h22);
      chk("p3_b2_last", o1_last, 0);
      drive(1, 8'h33, 1, 1);
      step();
      chk("p3_b3_o1", o1, 8'h33);
      chk("p3_b3_last", o1_last, 1);
      chk("p3_cnt1", pkt1_cnt, 1);
      chk("p3_o0v", o0_valid, 0);
      drive(0, 8'h00, 0, 0);
      step();
      chk("p3_drained", o1_valid, 0);

      // s toggles mid-packet: route stays locked on out1
      drive(1, 8'hA1, 0, 1);
      step();
      chk("lock_b1", o1, 8'hA1);
      drive(1, 8'hA2, 0, 0);
      step();
      chk("lock_b2", o1, 8'hA2);
      chk("lock_b2_o0v", o0_valid, 0);
      drive(1, 8'hA3, 0, 0);
      step();
      chk("lock_b3", o1, 8'hA3);
      drive(1, 8'hA4, 1, 0);
      step();
      chk("lock_b4", o1, 8'hA4);
      chk("lock_b4_last", o1_last, 1);
      chk("lock_o0v", o0_valid, 0);
      chk("lock_cnt1", pkt1_cnt, 2);
      drive(1, 8'hB1, 1, 0);
      step();
      chk("after_lock_o0", o0, 8'hB1);
      chk("after_lock_o0v", o0_valid, 1);
      chk("after_lock_o1v", o1_valid, 0);
      chk("after_lock_cnt0", pkt0_cnt, 1);
      drive(0, 8'h00, 0, 0);
      step();

      // Backpressure on out0
      o0_ready = 1'b0;
      drive(1, 8'hA5, 0, 0);
      #1;
      chk("bp_ready_pre", i_ready, 1);
      step();
      chk("bp_o0", o0, 8'hA5);
      chk("bp_o0v", o0_valid, 1);
      chk("bp_ready_low", i_ready, 0);
      drive(1, 8'h5B, 0, 0);
      step();
      chk("bp_hold1", o0, 8'hA5);
      chk("bp_hold1_ready", i_ready, 0);
      step();
      chk("bp_hold2", o0, 8'hA5);
      o0_ready = 1'b1;
      #1;
      chk("bp_release_ready", i_ready, 1);
      step();
      chk("bp_b2", o0, 8'h5B);
      chk("bp_b2_last", o0_last, 0);
      drive(1, 8'hC3, 1, 0);
      step();
      chk("bp_b3", o0, 8'hC3);
      chk("bp_b3_last", o0_last, 1);
      chk("bp_cnt0", pkt0_cnt, 2);
      drive(0, 8'h00, 0, 0);
      step();
      chk("bp_drained", o0_valid, 0);

      // Alternating single-beat packets
      do_reset();
      drive(1, 8'h01, 1, 0);
      step();
      chk("alt1_o0", o0, 8'h01);
      chk("alt1_o1v", o1_valid, 0);
      drive(1, 8'h02, 1, 1);
      step();
      chk("alt2_o1", o1, 8'h02);
      chk("alt2_o0v", o0_valid, 0);
      drive(1, 8'h03, 1, 0);
      step();
      chk("alt3_o0", o0, 8'h03);
      chk("alt3_o1v", o1_valid, 0);
      drive(1, 8'h04, 1, 1);
      step();
      chk("alt4_o1", o1, 8'h04);
      chk("alt4_o1v", o1_valid, 1);
      chk("alt_cnt0", pkt0_cnt, 2);
      chk("alt_cnt1", pkt1_cnt, 2);
      drive(0, 8'h00, 0, 0);
      step();

      // Counter wrap with COUNT_W=2
      do_reset();
      for (int k = 0; k < 5; k++) begin
         drive(1, 8'h40 + 8'(k), 1, 0);
         step();
         chk($sformatf("wrap_%0d", k), pkt0_cnt, (k + 1) % 4);
      end
      drive(0, 8'h00, 0, 0);
      step();

      // Reset mid-packet with an unconsumed beat on out1
      o1_ready = 1'b0;
      drive(1, 8'h77, 0, 1);
      step();
      chk("mid_o1v", o1_valid, 1);
      drive(0, 8'h00, 0, 0);
      rst = 1'b1;
      #1;
      chk("mid_rst_o1v", o1_valid, 0);
      chk("mid_rst_o1", o1, 0);
      step();
      rst = 1'b0;
      o1_ready = 1'b1;
      drive(1, 8'h88, 1, 0);
      step();
      chk("mid_next_o0", o0, 8'h88);
      chk("mid_next_o0v", o0_valid, 1);
      chk("mid_next_o1v", o1_valid, 0);
      chk("mid_next_cnt0", pkt0_cnt, 1);
      drive(0, 8'h00, 0, 0);
      step();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
